// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: E-stage forwarding,
// load-use stalls, branch flushes, data-memory wait freezes, timeout trap and perf counters.
module hazard_controller #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RS1E,
    input  logic [4:0]       RS2E,
    input  logic [4:0]       RDE,
    input  logic [4:0]       RDM,
    input  logic [4:0]       RDW,
    input  logic             ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             BubbleW,
    output logic             mem_err,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    localparam logic [3:0]       LP_INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [8:0]       LP_TIMEOUT   = 9'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_init_cnt;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_lw_cnt;
    logic [CNT_W-1:0] r_ms_cnt;
    logic [CNT_W-1:0] r_fl_cnt;

    logic       w_lw_stall;
    logic       w_mem_wait;
    logic       w_active;
    logic       w_run_eq;
    logic [8:0] w_wait_inc;
    logic       w_timeout;

    assign w_lw_stall = ResultSrcE && (RDE != 5'd0) && ((RDE == RS1D) || (RDE == RS2D));
    assign w_mem_wait = MemReqM && !MemReadyM;
    assign w_active   = (r_state == S_RUN) || (r_state == S_MEM_WAIT);
    // The MEM_WAIT exit cycle uses the RUN equations, so held hazards are counted there.
    assign w_run_eq   = w_active && !w_mem_wait;
    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout  = (w_wait_inc >= LP_TIMEOUT);

    // Forwarding is state-independent but forced to register-file select while in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst) begin
            if (RegWriteM && (RDM != 5'd0) && (RDM == RS1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RDW != 5'd0) && (RDW == RS1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RDM != 5'd0) && (RDM == RS2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RDW != 5'd0) && (RDW == RS2E)) ForwardBE = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_INIT;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:     if (r_init_cnt == LP_INIT_LAST) w_next_state = S_RUN;
            S_RUN:      if (w_mem_wait) w_next_state = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (!w_mem_wait)    w_next_state = S_RUN;
                else if (w_timeout) w_next_state = S_ERROR;
            end
            S_ERROR:    w_next_state = S_ERROR;
            default:    w_next_state = S_INIT;
        endcase
    end

    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        BubbleW = 1'b0;
        case (r_state)
            S_RUN, S_MEM_WAIT: begin
                if (w_mem_wait) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    StallM  = 1'b1;
                    BubbleW = 1'b1;
                end else begin
                    StallF = w_lw_stall;
                    StallD = w_lw_stall;
                    FlushD = PCSrcE;
                    FlushE = w_lw_stall || PCSrcE;
                end
            end
            S_ERROR: begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                StallM  = 1'b1;
                BubbleW = 1'b1;
            end
            default: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init_cnt <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == S_INIT) r_init_cnt <= r_init_cnt + 4'd1;
            if ((r_state == S_RUN) && w_mem_wait) begin
                r_wait_cnt <= 8'd1;
            end else if ((r_state == S_MEM_WAIT) && w_mem_wait) begin
                r_wait_cnt <= w_wait_inc[7:0];
                if (w_timeout) r_mem_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lw_cnt <= '0;
            r_ms_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_run_eq && w_lw_stall && (r_lw_cnt != '1)) r_lw_cnt <= r_lw_cnt + LP_CNT_ONE;
            if (w_active && w_mem_wait && (r_ms_cnt != '1)) r_ms_cnt <= r_ms_cnt + LP_CNT_ONE;
            if (w_run_eq && PCSrcE && (r_fl_cnt != '1))     r_fl_cnt <= r_fl_cnt + LP_CNT_ONE;
        end
    end

    assign mem_err       = r_mem_err;
    assign lw_stall_cnt  = r_lw_cnt;
    assign mem_stall_cnt = r_ms_cnt;
    assign flush_cnt     = r_fl_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a behavioural pipeline-hazard model.
module tb_hazard_controller;

    localparam int unsigned INIT_CYCLES = 2;
    localparam int unsigned TIMEOUT     = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int          SAT         = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [4:0]       RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
    logic             ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW, mem_err;
    logic [CNT_W-1:0] lw_stall_cnt, mem_stall_cnt, flush_cnt;

    hazard_controller #(
        .INIT_CYCLES(INIT_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RS1D         (RS1D),
        .RS2D         (RS2D),
        .RS1E         (RS1E),
        .RS2E         (RS2E),
        .RDE          (RDE),
        .RDM          (RDM),
        .RDW          (RDW),
        .ResultSrcE   (ResultSrcE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .PCSrcE       (PCSrcE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .BubbleW      (BubbleW),
        .mem_err      (mem_err),
        .lw_stall_cnt (lw_stall_cnt),
        .mem_stall_cnt(mem_stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_err;

    // Model: pipeline phase tracked as "still filling", "consecutive wait cycles" and "trapped".
    bit m_filling;
    int m_fill_done;
    int m_waiting;
    bit m_trapped;
    int m_lw, m_ms, m_fl;

    function automatic void model_reset();
        m_filling   = 1'b1;
        m_fill_done = 0;
        m_waiting   = 0;
        m_trapped   = 1'b0;
        m_lw = 0;
        m_ms = 0;
        m_fl = 0;
    endfunction

    function automatic int sat_inc(int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    function automatic logic [1:0] fwd(logic [4:0] rs);
        if (!rst) return 2'b00;
        if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
        if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        return ResultSrcE && RDE != 0 && (RDE == RS1D || RDE == RS2D);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle();
        bit lw, mw, frz, fill;
        if (!rst) model_reset();
        @(negedge clk);
        lw   = load_use();
        mw   = MemReqM && !MemReadyM;
        fill = !rst || m_filling;
        frz  = !fill && (m_trapped || mw);
        chk("ForwardAE", 16'(ForwardAE), 16'(fwd(RS1E)));
        chk("ForwardBE", 16'(ForwardBE), 16'(fwd(RS2E)));
        chk("StallF",  16'(StallF),  16'(fill || frz || lw));
        chk("StallD",  16'(StallD),  16'(!fill && (frz || lw)));
        chk("StallE",  16'(StallE),  16'(frz));
        chk("StallM",  16'(StallM),  16'(frz));
        chk("BubbleW", 16'(BubbleW), 16'(frz));
        chk("FlushD",  16'(FlushD),  16'(fill || (!frz && PCSrcE)));
        chk("FlushE",  16'(FlushE),  16'(fill || (!frz && (PCSrcE || lw))));
        chk("mem_err", 16'(mem_err), 16'(m_trapped));
        chk("lw_stall_cnt",  16'(lw_stall_cnt),  16'(m_lw));
        chk("mem_stall_cnt", 16'(mem_stall_cnt), 16'(m_ms));
        chk("flush_cnt",     16'(flush_cnt),     16'(m_fl));
        @(posedge clk);
        if (rst) begin
            if (m_filling) begin
                m_fill_done++;
                if (m_fill_done == int'(INIT_CYCLES)) m_filling = 1'b0;
            end else if (!m_trapped) begin
                if (mw) begin
                    m_waiting++;
                    m_ms = sat_inc(m_ms);
                    if (m_waiting == int'(TIMEOUT)) m_trapped = 1'b1;
                end else begin
                    m_waiting = 0;
                    if (lw) m_lw = sat_inc(m_lw);
                    if (PCSrcE) m_fl = sat_inc(m_fl);
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        {RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW} = '0;
        {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst = 1'b0;
        clear_inputs();
        RegWriteM = 1'b1; RDM = 5'd3; RS1E = 5'd3;
        cycle();
        clear_inputs();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        cycle();
        cycle();

        RegWriteM = 1'b1; RDM = 5'd5; RegWriteW = 1'b1; RDW = 5'd5; RS1E = 5'd5; RS2E = 5'd0;
        cycle();
        RDM = 5'd0;
        cycle();
        RS2E = 5'd5; RDM = 5'd9; RS1E = 5'd9;
        cycle();
        clear_inputs();

        ResultSrcE = 1'b1; RDE = 5'd7; RS2D = 5'd7;
        cycle();
        clear_inputs();
        ResultSrcE = 1'b1; RDE = 5'd0; RS1D = 5'd0;
        cycle();
        clear_inputs();
        cycle();

        PCSrcE = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        repeat (3) cycle();
        MemReadyM = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        MemReqM = 1'b1; MemReadyM = 1'b0; ResultSrcE = 1'b1; RDE = 5'd4; RS1D = 5'd4;
        cycle();
        MemReqM = 1'b0;
        cycle();
        clear_inputs();
        cycle();

        MemReqM = 1'b1; MemReadyM = 1'b0;
        repeat (7) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        clear_inputs();
        repeat (4) cycle();

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            if (m_trapped && $urandom_range(0, 5) == 0) rst = 1'b0;
            RS1D = 5'($urandom_range(0, 3));
            RS2D = 5'($urandom_range(0, 3));
            RS1E = 5'($urandom_range(0, 3));
            RS2E = 5'($urandom_range(0, 3));
            RDE  = 5'($urandom_range(0, 3));
            RDM  = 5'($urandom_range(0, 3));
            RDW  = 5'($urandom_range(0, 3));
            ResultSrcE = ($urandom_range(0, 2) == 0);
            PCSrcE     = ResultSrcE ? 1'b0 : ($urandom_range(0, 3) == 0);
            RegWriteM  = $urandom_range(0, 1) == 1;
            RegWriteW  = $urandom_range(0, 1) == 1;
            MemReqM    = $urandom_range(0, 1) == 1;
            MemReadyM  = $urandom_range(0, 3) == 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
